// File: rtl/regheap_acc_ctrl.sv
// ---------------------------------------------------------------------------
// regheap_acc_ctrl
//
// Sequencing controller for a 64-entry accumulator heap. A job clears the
// heap, streams cfg_len input vectors into it, waits for the heap pipeline
// to settle, then flags the result as readable.
//
// Parameters
//   CNT_W     width of the job length field and the beat counter
//   HEAP_LAT  heap pipeline latency in cycles (1..15)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         begin a job (honoured in IDLE and DONE only)
//   cfg_len       number of vectors in the job, latched on start
//   abort         cancel the running job (ignored in IDLE)
//   in_v          upstream vector valid
//   in_rdy        vector accepted this cycle (state decode only)
//   heap_data_v   heap data_v strobe = in_v & in_rdy
//   heap_usr_rst  heap accumulator clear
//   out_v         one-cycle pulse: heap result is final
//   busy          job in progress
//   err           one-cycle pulse: start seen with cfg_len == 0
//   beat_cnt      vectors accepted in the current job
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no job; waits for start
// CLR   | one cycle, clears the heap accumulators
// ACC   | accepts vectors until cfg_len beats have been taken
// DRAIN | waits for the heap pipeline to settle
// DONE  | one cycle, out_v high; may chain straight into the next job
// ---------------------------------------------------------------------------
module regheap_acc_ctrl #(
    parameter int CNT_W    = 8,
    parameter int HEAP_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             abort,
    input  logic             in_v,
    output logic             in_rdy,
    output logic             heap_data_v,
    output logic             heap_usr_rst,
    output logic             out_v,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The drain counter is loaded on the final beat and counted down to zero
    // in DRAIN, so the final heap write has HEAP_LAT full cycles of margin
    // before DONE even after the counter's own load cycle.
    localparam logic [3:0] DRAIN_LOAD = 4'(HEAP_LAT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q,  beat_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic [3:0]       drain_q, drain_d;
    logic             usr_rst_q, usr_rst_d;
    logic             out_v_q,   out_v_d;
    logic             err_q,     err_d;

    logic start_ok;
    logic start_bad;
    logic beat;
    logic last_beat;

    assign start_ok  = start && (cfg_len != '0);
    assign start_bad = start && (cfg_len == '0);
    assign beat      = in_v && (state_q == S_ACC);
    assign last_beat = (beat_q == (len_q - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            len_q     <= '0;
            drain_q   <= '0;
            usr_rst_q <= 1'b0;
            out_v_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            drain_q   <= drain_d;
            usr_rst_q <= usr_rst_d;
            out_v_q   <= out_v_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        len_d     = len_q;
        drain_d   = drain_q;
        usr_rst_d = 1'b0;
        err_d     = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            // Abort beats everything, including a final beat in the same cycle.
            state_d   = S_IDLE;
            beat_d    = '0;
            usr_rst_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        len_d   = cfg_len;
                        beat_d  = '0;
                        state_d = S_CLR;
                    end else if (start_bad) begin
                        err_d = 1'b1;
                    end
                end
                S_CLR: begin
                    state_d = S_ACC;
                end
                S_ACC: begin
                    if (beat) begin
                        beat_d = beat_q + 1'b1;
                        if (last_beat) begin
                            drain_d = DRAIN_LOAD;
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (start_ok) begin
                        len_d   = cfg_len;
                        beat_d  = '0;
                        state_d = S_CLR;
                    end else begin
                        err_d   = start_bad;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Registered pulses are keyed on the next state so they line up with
        // the cycle the FSM spends in CLR / DONE.
        if (state_d == S_CLR) begin
            usr_rst_d = 1'b1;
        end
        out_v_d = (state_d == S_DONE);
    end

    assign in_rdy       = (state_q == S_ACC);
    assign heap_data_v  = in_v && in_rdy;
    assign heap_usr_rst = usr_rst_q;
    assign out_v        = out_v_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;
    assign beat_cnt     = beat_q;

endmodule
